// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the systolic array output path.
package systolic_pkg;

    // Default array geometry used when a block is not overridden.
    localparam int MATRIX_SIZE_DEF = 2;
    localparam int DATA_SIZE_DEF   = 32;

    // Width of a counter that must represent 0..n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    localparam int CNT_W = cnt_width(MATRIX_SIZE_DEF);

    // Write-side state of the deskewer row FIFO.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } deskew_state_e;

    // One aligned result row.
    typedef logic [DATA_SIZE_DEF-1:0] row_t [MATRIX_SIZE_DEF];

endpackage

// File: rtl/deskew_delay_line.sv
// Fixed-length register delay line; DEPTH=0 degenerates to a plain wire.
module deskew_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_ok;
            assign unused_ok = clk ^ reset;
            assign q_o = d_i;
        end else begin : g_reg
            logic [WIDTH-1:0] stage_q [DEPTH];

            // Shift the input through DEPTH stages, clearing in-flight data on reset.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_q[i] <= '0;
                    end
                end else begin
                    stage_q[0] <= d_i;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign q_o = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/output_deskewer.sv
// Realigns skewed systolic-array column outputs into whole rows, buffers one
// frame of rows in a FIFO and hands them on over valid/ready.
// Optional feature: define OUTPUT_DESKEWER_RELU_EN to clamp negative elements
// to zero on the FIFO write path.
module output_deskewer
    import systolic_pkg::*;
#(
    parameter int MATRIX_SIZE = MATRIX_SIZE_DEF,
    parameter int DATA_SIZE   = DATA_SIZE_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_SIZE-1:0] result_in [MATRIX_SIZE],
    input  logic                 result_valid,
    output logic [DATA_SIZE-1:0] row_out [MATRIX_SIZE],
    output logic                 row_valid,
    input  logic                 row_ready,
    output logic                 frame_done,
    output logic                 overflow
);

    localparam int CW = cnt_width(MATRIX_SIZE);
    localparam int PW = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(MATRIX_SIZE - 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(MATRIX_SIZE - 1);

    // Element transform applied as a row enters the FIFO.
    function automatic logic [DATA_SIZE-1:0] store_elem(input logic signed [DATA_SIZE-1:0] x);
`ifdef OUTPUT_DESKEWER_RELU_EN
        return (x < 0) ? '0 : x;
`else
        return x;
`endif
    endfunction

    // Pointer increment wrapping modulo MATRIX_SIZE.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    logic [DATA_SIZE-1:0] aligned [MATRIX_SIZE];
    logic                 aligned_vld;

    // Column j waits N-1-j cycles so every column lines up with column N-1.
    generate
        for (genvar j = 0; j < MATRIX_SIZE; j++) begin : g_col
            deskew_delay_line #(
                .DEPTH(MATRIX_SIZE - 1 - j),
                .WIDTH(DATA_SIZE)
            ) u_col (
                .clk  (clk),
                .reset(reset),
                .d_i  (result_in[j]),
                .q_o  (aligned[j])
            );
        end
    endgenerate

    deskew_delay_line #(
        .DEPTH(MATRIX_SIZE - 1),
        .WIDTH(1)
    ) u_vld (
        .clk  (clk),
        .reset(reset),
        .d_i  (result_valid),
        .q_o  (aligned_vld)
    );

    deskew_state_e        state_q, state_d;
    logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]        count_q, count_d;
    logic [CW-1:0]        wcnt_q, wcnt_d;
    logic [CW-1:0]        pcnt_q, pcnt_d;
    logic                 overflow_q, overflow_d;
    logic                 wr_en;
    logic                 pop;
    logic [DATA_SIZE-1:0] mem_q [MATRIX_SIZE][MATRIX_SIZE];

    assign row_valid = (count_q != '0);
    assign pop       = row_valid && row_ready;
    assign overflow  = overflow_q;

    // Head-of-FIFO row is presented straight from storage.
    always_comb begin
        for (int j = 0; j < MATRIX_SIZE; j++) begin
            row_out[j] = mem_q[rd_ptr_q][j];
        end
    end

    // Write-side FSM, frame counters and FIFO occupancy next-state.
    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        pcnt_d     = pcnt_q;
        overflow_d = overflow_q;
        wr_en      = 1'b0;
        frame_done = 1'b0;

        if (pop) begin
            pcnt_d = pcnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (aligned_vld) begin
                    wr_en   = 1'b1;
                    wcnt_d  = CW'(1);
                    state_d = (MATRIX_SIZE == 1) ? DRAIN : COLLECT;
                end
            end
            COLLECT: begin
                if (aligned_vld) begin
                    wr_en  = 1'b1;
                    wcnt_d = wcnt_q + 1'b1;
                    if (wcnt_q == LAST_CNT) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // The frame is complete; any further row has nowhere to go.
                if (aligned_vld) begin
                    overflow_d = 1'b1;
                end
                if (pop && (pcnt_q == LAST_CNT)) begin
                    frame_done = 1'b1;
                    state_d    = IDLE;
                    wcnt_d     = '0;
                    pcnt_d     = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        case ({wr_en, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            wcnt_q     <= '0;
            pcnt_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            wcnt_q     <= wcnt_d;
            pcnt_q     <= pcnt_d;
            overflow_q <= overflow_d;
            if (wr_en) begin
                wr_ptr_q <= next_ptr(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
        end
    end

    // Row storage; cleared on reset so row_out reads zero until the first write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < MATRIX_SIZE; r++) begin
                for (int j = 0; j < MATRIX_SIZE; j++) begin
                    mem_q[r][j] <= '0;
                end
            end
        end else if (wr_en) begin
            for (int j = 0; j < MATRIX_SIZE; j++) begin
                mem_q[wr_ptr_q][j] <= store_elem(aligned[j]);
            end
        end
    end

endmodule
